imem_port_arbiter: RTL and testbench

Shares the single-port 32-word instruction/test memory between the instruction-fetch requester and the data (load/store) requester. Per cycle it grants at most one requester, drives the memory's address, read-enable and write controls, and routes the returned read word back to its owner with fixed one-cycle latency. Data accesses have priority, bounded by a starvation guard that forces a fetch grant after a configurable run of data grants.

---
 rtl/imem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction/test memory between fetch and data requesters; data wins, with a fetch forced after MAX_D_RUN data grants.
// Latency: grant and memory command in the request cycle; read word returned to its owner one cycle later.
// Backpressure: requesters hold req until granted; the arbiter never stalls and accepts one access per cycle.
module imem_port_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int MAX_D_RUN = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_rd_en_o,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wr_data_o,
    input  logic [DW-1:0] mem_rd_data_i
);

    localparam int              RW      = $clog2(MAX_D_RUN + 1);
    localparam logic [RW-1:0]   RUN_MAX = RW'(MAX_D_RUN);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_e;

    typedef struct packed {
        logic          rd_en;
        logic          wr_en;
        logic [AW-1:0] addr;
        logic [DW-1:0] wr_data;
    } mem_cmd_t;

    logic [RW-1:0] d_run_q;
    logic [RW-1:0] d_run_nxt;
    rsp_e          rsp_q;
    rsp_e          rsp_nxt;
    logic          force_if;
    logic          d_gnt;
    logic          if_gnt;
    mem_cmd_t      cmd;

    // Starvation guard: a waiting fetch wins once the data run has saturated.
    always_comb begin
        force_if = if_req_i && (d_run_q == RUN_MAX);
        d_gnt    = d_req_i && !force_if;
        if_gnt   = if_req_i && !d_gnt;
    end

    always_comb begin
        d_run_nxt = d_run_q;
        if (!if_req_i || if_gnt) begin
            d_run_nxt = '0;
        end else if (d_gnt && (d_run_q != RUN_MAX)) begin
            d_run_nxt = d_run_q + 1'b1;
        end
    end

    always_comb begin
        cmd = '0;
        if (if_gnt) begin
            cmd.rd_en = 1'b1;
            cmd.addr  = if_addr_i;
        end else if (d_gnt) begin
            cmd.addr = d_addr_i;
            if (d_we_i) begin
                cmd.wr_en   = 1'b1;
                cmd.wr_data = d_wdata_i;
            end else begin
                cmd.rd_en = 1'b1;
            end
        end
    end

    assign if_gnt_o      = if_gnt;
    assign d_gnt_o       = d_gnt;
    assign mem_rd_en_o   = cmd.rd_en;
    assign mem_wr_en_o   = cmd.wr_en;
    assign mem_addr_o    = cmd.addr;
    assign mem_wr_data_o = cmd.wr_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_run_q <= '0;
            rsp_q   <= RSP_NONE;
        end else begin
            d_run_q <= d_run_nxt;
            rsp_q   <= rsp_nxt;
        end
    end

    // Response owner: rsp_q names who the word on mem_rd_data_i belongs to this cycle.
    always_comb begin
        rsp_nxt     = RSP_NONE;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        if (if_gnt) begin
            rsp_nxt = RSP_IF;
        end else if (d_gnt && !d_we_i) begin
            rsp_nxt = RSP_D;
        end
        case (rsp_q)
            RSP_IF: begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rd_data_i;
            end
            RSP_D: begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = mem_rd_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized traffic checked each cycle
// against a behavioural arbitration/memory model; a MAX_D_RUN=1 instance checks alternation.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        chk_en;
    logic        if_req, d_req, d_we;
    logic [4:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_gnt, d_gnt, if_rvalid, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;

    logic        u1_if_gnt, u1_d_gnt, u1_if_rvalid, u1_d_rvalid, u1_rd_en, u1_wr_en;
    logic [31:0] u1_if_rdata, u1_d_rdata, u1_wr_data;
    logic [4:0]  u1_addr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.DW(32), .AW(5), .MAX_D_RUN(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
        .mem_wr_data_o(mem_wr_data), .mem_rd_data_i(mem_rd_data)
    );

    imem_port_arbiter #(.DW(32), .AW(5), .MAX_D_RUN(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(u1_if_gnt),
        .if_rvalid_o(u1_if_rvalid), .if_rdata_o(u1_if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(u1_d_gnt), .d_rvalid_o(u1_d_rvalid), .d_rdata_o(u1_d_rdata),
        .mem_rd_en_o(u1_rd_en), .mem_wr_en_o(u1_wr_en), .mem_addr_o(u1_addr),
        .mem_wr_data_o(u1_wr_data), .mem_rd_data_i(32'h0)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0003_0507);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Single-port memory with one-cycle registered read; unread cycles return noise.
    logic [31:0] mem_arr [32];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= init_word(i);
        end else if (mem_wr_en) begin
            mem_arr[mem_addr] <= mem_wr_data;
        end
        mem_rd_data <= mem_rd_en ? mem_arr[mem_addr] : $urandom;
    end

    // Reference model: arbitration rules, shadow memory and the owner of next cycle's word.
    logic [31:0] ref_mem [32];
    int          ref_run;
    int          exp_owner;  // 0 none, 1 fetch, 2 data
    logic [31:0] exp_word;

    always @(negedge clk) begin : compare
        logic eg_if, eg_d;
        if (mem_init) for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        if (rst) begin
            ref_run   = 0;
            exp_owner = 0;
            if (chk_en) begin
                chk("rst_if_rvalid", if_rvalid, 0);
                chk("rst_d_rvalid", d_rvalid, 0);
                chk("rst_if_rdata", if_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
            end
        end else if (chk_en) begin
            eg_d  = d_req && !(if_req && ref_run >= 2);
            eg_if = if_req && !eg_d;
            chk("if_gnt", if_gnt, eg_if);
            chk("d_gnt", d_gnt, eg_d);
            chk("mem_rd_en", mem_rd_en, eg_if || (eg_d && !d_we));
            chk("mem_wr_en", mem_wr_en, eg_d && d_we);
            chk("mem_addr", mem_addr, eg_if ? if_addr : (eg_d ? d_addr : 5'd0));
            chk("mem_wr_data", mem_wr_data, (eg_d && d_we) ? d_wdata : 32'd0);
            chk("if_rvalid", if_rvalid, exp_owner == 1);
            chk("d_rvalid", d_rvalid, exp_owner == 2);
            chk("if_rdata", if_rdata, (exp_owner == 1) ? exp_word : 32'd0);
            chk("d_rdata", d_rdata, (exp_owner == 2) ? exp_word : 32'd0);
            chk("u1_gnt_excl", u1_if_gnt & u1_d_gnt, 0);
            chk("u1_rvalid_excl", u1_if_rvalid & u1_d_rvalid, 0);
            exp_owner = eg_if ? 1 : ((eg_d && !d_we) ? 2 : 0);
            exp_word  = eg_if ? ref_mem[if_addr] : ref_mem[d_addr];
            if (eg_d && d_we) ref_mem[d_addr] = d_wdata;
            if (!if_req || eg_if) ref_run = 0;
            else if (eg_d && ref_run < 2) ref_run++;
        end
    end

    task automatic drive(input logic ir, input logic [4:0] ia, input logic dr, input logic dw,
                         input logic [4:0] da, input logic [31:0] dd);
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    logic [5:0] seq0, seq1;
    logic       l_if_gnt, l_d_gnt;

    initial begin
        rst = 1'b1; mem_init = 1'b1; chk_en = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        seq0 = '0; seq1 = '0;
        @(posedge clk); @(posedge clk); #1;
        mem_init = 1'b0;
        settle();
        chk("reset_if_rvalid", if_rvalid, 0);
        chk("reset_d_rvalid", d_rvalid, 0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);
        chk("reset_gnt", {if_gnt, d_gnt, mem_rd_en, mem_wr_en}, 0);
        @(posedge clk); #1;
        rst = 1'b0; chk_en = 1'b1;

        // Fetch only, addresses 0,1,2 back to back
        for (int a = 0; a < 3; a++) begin
            drive(1, 5'(a), 0, 0, 0, 0);
            settle();
            chk("fetch_gnt", if_gnt, 1);
            if (a > 0) chk("fetch_rdata", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b1, init_word(a - 1)});
        end
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("fetch_last_rdata", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b1, init_word(2)});
        chk("fetch_no_d_rvalid", d_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("idle_mem", {mem_rd_en, mem_wr_en, mem_addr}, 0);
        chk("idle_rvalid", {if_rvalid, d_rvalid}, 0);

        // Continuous dual request: D,D,IF pattern and strict alternation for MAX_D_RUN=1
        for (int c = 0; c < 6; c++) begin
            drive(1, 5'($urandom), 1, 0, 5'($urandom), 0);
            settle();
            seq0 = {seq0[4:0], d_gnt};
            seq1 = {seq1[4:0], u1_d_gnt};
        end
        chk("dual_seq_max2", seq0, 6'b110110);
        chk("dual_seq_max1", seq1, 6'b101010);

        // Store then load of the same address
        drive(0, 0, 1, 1, 5'd7, 32'hDEAD_BEEF);
        settle();
        chk("store_wr_en", {mem_wr_en, mem_rd_en}, 2'b10);
        drive(0, 0, 1, 0, 5'd7, 0);
        settle();
        chk("store_no_rvalid", d_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("load_after_store", {31'd0, d_rvalid, d_rdata}, {31'd0, 1'b1, 32'hDEAD_BEEF});

        // Data-only run does not build up a forced fetch
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 1, 1'($urandom), 5'($urandom), $urandom);
            settle();
            chk("data_only_gnt", d_gnt, 1);
        end
        drive(1, 5'd3, 1, 0, 5'd4, 0);
        settle();
        chk("fetch_arrives_data_wins", {if_gnt, d_gnt}, 2'b01);

        // Reset while a fetch response is returning
        drive(1, 5'd5, 0, 0, 0, 0);
        settle();
        chk("pre_rst_fetch_gnt", if_gnt, 1);
        @(posedge clk); #1;
        if_req = 0;
        chk("pre_rst_rvalid", if_rvalid, 1);
        #1 rst = 1'b1;
        #1 chk("rst_drops_rvalid", if_rvalid, 0);
        @(posedge clk); #3 rst = 1'b0;
        settle();
        chk("post_rst_rvalid", {if_rvalid, d_rvalid}, 0);
        drive(1, 5'd9, 0, 0, 0, 0);
        settle();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("post_rst_fetch", if_rvalid, 1);

        // Randomized traffic, requests held until granted with occasional drops
        l_if_gnt = 0; l_d_gnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!(if_req && !l_if_gnt && $urandom_range(0, 7) != 0)) begin
                if_req  = $urandom_range(0, 2) != 0;
                if_addr = 5'($urandom);
            end
            if (!(d_req && !l_d_gnt && $urandom_range(0, 7) != 0)) begin
                d_req   = $urandom_range(0, 2) != 0;
                d_we    = $urandom_range(0, 2) == 0;
                d_addr  = 5'($urandom_range(0, 7));
                d_wdata = $urandom;
            end
            settle();
            l_if_gnt = if_gnt;
            l_d_gnt  = d_gnt;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
